// File: rtl/dk_sound_mixer.sv
// ============================================================================
// Module      : dk_sound_mixer
// Description : Final mixing stage of the DK discrete-sound chain. On each
//               audio sample strobe it snapshots four signed 16-bit circuit
//               outputs, applies per-channel Q2.14 gain and mute, sums them
//               with a sequential multiply-accumulate (one channel per clock),
//               saturates the result to 16 bits and emits a one-cycle valid.
// Ports       : clk          - system clock
//               reset        - asynchronous, active-high reset
//               audio_clk_en - one-cycle sample strobe
//               in_0..in_3   - signed circuit outputs (in_0 = walk)
//               mute[3:0]    - bit n forces channel n's contribution to 0
//               out          - signed mixed sample, held between updates
//               out_valid    - one-cycle pulse when out updates
//               clipped      - pulses with out_valid when the sum saturated
//               overrun      - sticky; a strobe arrived while busy
// Config      : `DK_MIXER_DC_BLOCK_EN inserts a first-order DC blocker
//               (pole set by DC_SHIFT) ahead of saturation and adds one
//               cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dk_sound_mixer #(
  parameter int unsigned GAIN_0   = 16384,
  parameter int unsigned GAIN_1   = 16384,
  parameter int unsigned GAIN_2   = 16384,
  parameter int unsigned GAIN_3   = 16384,
  parameter int unsigned DC_SHIFT = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               audio_clk_en,
  input  logic signed [15:0] in_0,
  input  logic signed [15:0] in_1,
  input  logic signed [15:0] in_2,
  input  logic signed [15:0] in_3,
  input  logic        [3:0]  mute,
  output logic signed [15:0] out,
  output logic               out_valid,
  output logic               clipped,
  output logic               overrun
);

  // Gains are unsigned Q2.14; a zero MSB makes them non-negative 17-bit signed.
  localparam logic signed [16:0] c_G0 = {1'b0, 16'(GAIN_0)};
  localparam logic signed [16:0] c_G1 = {1'b0, 16'(GAIN_1)};
  localparam logic signed [16:0] c_G2 = {1'b0, 16'(GAIN_2)};
  localparam logic signed [16:0] c_G3 = {1'b0, 16'(GAIN_3)};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SCALE = 2'd2,
    S_DCB   = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic                      w_overrun_set;
  logic signed [15:0]        r_snap [4];
  logic        [3:0]         r_mute;
  logic        [1:0]         r_idx;
  logic signed [35:0]        r_acc;
  logic signed [15:0]        w_sample;
  logic signed [16:0]        w_gain;
  logic signed [32:0]        w_prod;
  logic signed [21:0]        w_s;
  logic signed [26:0]        w_sat_in;
  logic        [16:0]        w_sat;

  // Returns {clip_flag, saturated_value}.
  function automatic logic [16:0] f_sat16(input logic signed [26:0] v);
    if (v > 27'sd32767)       return {1'b1, 16'h7fff};
    else if (v < -27'sd32768) return {1'b1, 16'h8000};
    else                      return {1'b0, v[15:0]};
  endfunction

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_overrun_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (audio_clk_en) w_state_next = S_ACCUM;
      end
      S_ACCUM: begin
        w_overrun_set = audio_clk_en;
        if (r_idx == 2'd3) w_state_next = S_SCALE;
      end
      S_SCALE: begin
        w_overrun_set = audio_clk_en;
`ifdef DK_MIXER_DC_BLOCK_EN
        w_state_next  = S_DCB;
`else
        w_state_next  = S_IDLE;
`endif
      end
      default: begin
        w_overrun_set = audio_clk_en;
        w_state_next  = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Multiply-accumulate datapath
  // --------------------------------------------------------------------------
  always_comb begin
    w_sample = r_snap[r_idx];
    case (r_idx)
      2'd0:    w_gain = c_G0;
      2'd1:    w_gain = c_G1;
      2'd2:    w_gain = c_G2;
      default: w_gain = c_G3;
    endcase
    w_prod = r_mute[r_idx] ? 33'sd0 : w_sample * w_gain;
  end

  // Drop the Q2.14 fraction.
  assign w_s = r_acc[35:14];

`ifdef DK_MIXER_DC_BLOCK_EN
  // y = s - x1 + y1 - (y1 >>> DC_SHIFT), evaluated in SCALE; the blocker
  // state is clamped to 24 bits so a pathological input cannot wrap it.
  logic signed [23:0] r_x1;
  logic signed [23:0] r_y1;
  logic signed [23:0] w_y1_sh;
  logic signed [26:0] w_y;
  logic signed [23:0] w_y1_next;

  assign w_y1_sh   = r_y1 >>> DC_SHIFT;
  assign w_y       = {{5{w_s[21]}}, w_s} - {{3{r_x1[23]}}, r_x1}
                   + {{3{r_y1[23]}}, r_y1} - {{3{w_y1_sh[23]}}, w_y1_sh};
  assign w_y1_next = (w_y > 27'sd8388607)  ? 24'sh7fffff :
                     (w_y < -27'sd8388608) ? 24'sh800000 : w_y[23:0];
  assign w_sat_in  = {{3{r_y1[23]}}, r_y1};
`else
  assign w_sat_in  = {{5{w_s[21]}}, w_s};
`endif

  assign w_sat = f_sat16(w_sat_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_snap[i] <= '0;
      r_mute    <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      clipped   <= 1'b0;
      overrun   <= 1'b0;
`ifdef DK_MIXER_DC_BLOCK_EN
      r_x1      <= '0;
      r_y1      <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      clipped   <= 1'b0;
      if (w_overrun_set) overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (audio_clk_en) begin
            r_snap[0] <= in_0;
            r_snap[1] <= in_1;
            r_snap[2] <= in_2;
            r_snap[3] <= in_3;
            r_mute    <= mute;
            r_acc     <= '0;
            r_idx     <= '0;
          end
        end
        S_ACCUM: begin
          r_acc <= r_acc + {{3{w_prod[32]}}, w_prod};
          r_idx <= r_idx + 2'd1;
        end
        S_SCALE: begin
`ifdef DK_MIXER_DC_BLOCK_EN
          r_x1 <= {{2{w_s[21]}}, w_s};
          r_y1 <= w_y1_next;
`else
          out       <= w_sat[15:0];
          clipped   <= w_sat[16];
          out_valid <= 1'b1;
`endif
        end
        default: begin
`ifdef DK_MIXER_DC_BLOCK_EN
          out       <= w_sat[15:0];
          clipped   <= w_sat[16];
          out_valid <= 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dk_sound_mixer.sv
// ============================================================================
// Module      : tb_dk_sound_mixer
// Description : Directed self-checking bench for dk_sound_mixer. A default
//               instance and one with GAIN_1 = 0.5 share all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dk_sound_mixer;

`ifdef DK_MIXER_DC_BLOCK_EN
  localparam int c_LAT = 7;
`else
  localparam int c_LAT = 6;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               audio_clk_en = 1'b0;
  logic signed [15:0] in_0 = '0, in_1 = '0, in_2 = '0, in_3 = '0;
  logic        [3:0]  mute = '0;
  logic signed [15:0] out, out_g;
  logic               out_valid, out_valid_g, clipped, clipped_g, overrun, overrun_g;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dk_sound_mixer dut (
    .clk(clk), .reset(reset), .audio_clk_en(audio_clk_en),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3), .mute(mute),
    .out(out), .out_valid(out_valid), .clipped(clipped), .overrun(overrun)
  );

  dk_sound_mixer #(.GAIN_1(8192)) dut_g (
    .clk(clk), .reset(reset), .audio_clk_en(audio_clk_en),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3), .mute(mute),
    .out(out_g), .out_valid(out_valid_g), .clipped(clipped_g), .overrun(overrun_g)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One strobe; lat counts edges from the one that samples the strobe to the
  // first out_valid, -1 if none within the budget.
  task automatic run_sample(output int lat, output logic signed [15:0] o, og,
                            output logic c, cg);
    lat = -1; o = '0; og = '0; c = 1'b0; cg = 1'b0;
    @(posedge clk); #1 audio_clk_en = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      if (lat < 0) begin
        @(posedge clk); #1 audio_clk_en = 1'b0;
        if (out_valid) begin
          lat = n; o = out; og = out_g; c = clipped; cg = clipped_g;
        end
      end
    end
    audio_clk_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out !== 16'sd0) begin errors++; $display("FAIL reset_out: got %0d want 0", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (clipped !== 1'b0) begin errors++; $display("FAIL reset_clipped: got %b want 0", clipped); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out !== 16'sd0) begin
      errors++; $display("FAIL post_reset_idle: valid %b out %0d want 0/0", out_valid, out);
    end
  endtask

  task automatic test_single;
    int lat; logic signed [15:0] o, og; logic c, cg;
    in_0 = 16'sd6826; in_1 = '0; in_2 = '0; in_3 = '0; mute = '0;
    run_sample(lat, o, og, c, cg);
    checks++; if (lat !== c_LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, c_LAT); end
    checks++; if (o !== 16'sd6826) begin errors++; $display("FAIL single_out: got %0d want 6826", o); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL single_clipped: got %b want 0", c); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b want 0", out_valid); end
    checks++; if (out !== 16'sd6826) begin errors++; $display("FAIL single_hold: got %0d want 6826", out); end
  endtask

  task automatic test_saturation;
    int lat; logic signed [15:0] o, og; logic c, cg;
    in_0 = 16'sd20000; in_1 = 16'sd20000; in_2 = '0; in_3 = '0; mute = '0;
    run_sample(lat, o, og, c, cg);
    checks++; if (o !== 16'sd32767) begin errors++; $display("FAIL sat_pos_out: got %0d want 32767", o); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL sat_pos_clipped: got %b want 1", c); end
    checks++; if (og !== 16'sd30000 || cg !== 1'b0) begin
      errors++; $display("FAIL sat_pos_half_gain: got %0d/%b want 30000/0", og, cg);
    end
    in_0 = -16'sd20000; in_1 = -16'sd20000;
    run_sample(lat, o, og, c, cg);
    checks++; if (o !== -16'sd32768) begin errors++; $display("FAIL sat_neg_out: got %0d want -32768", o); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL sat_neg_clipped: got %b want 1", c); end
  endtask

  task automatic test_gain_mute;
    int lat; logic signed [15:0] o, og; logic c, cg;
    in_0 = 16'sd5000; in_1 = -16'sd1000; in_2 = '0; in_3 = '0; mute = 4'b0001;
    run_sample(lat, o, og, c, cg);
    checks++; if (og !== -16'sd500) begin errors++; $display("FAIL gain_half_mute0: got %0d want -500", og); end
    checks++; if (o !== -16'sd1000) begin errors++; $display("FAIL gain_unity_mute0: got %0d want -1000", o); end
    in_0 = 16'sd100; in_1 = 16'sd200; in_2 = -16'sd300; in_3 = 16'sd400; mute = 4'b0000;
    run_sample(lat, o, og, c, cg);
    checks++; if (o !== 16'sd400 || og !== 16'sd300) begin
      errors++; $display("FAIL gain_four_ch: got %0d/%0d want 400/300", o, og);
    end
    in_0 = 16'sd12345; in_1 = -16'sd7; in_2 = 16'sd999; in_3 = 16'sd1; mute = 4'b1111;
    run_sample(lat, o, og, c, cg);
    checks++; if (lat !== c_LAT || o !== 16'sd0 || c !== 1'b0) begin
      errors++; $display("FAIL all_muted: lat %0d out %0d clip %b want %0d/0/0", lat, o, c, c_LAT);
    end
    mute = 4'b0000;
  endtask

  // Second strobe in cycle k of a sequence whose first strobe is in cycle 0;
  // in_0 changes right after the first latch.
  task automatic run_sched(input int k, output int nv, output int e1, e2,
                           output logic signed [15:0] o1, o2);
    nv = 0; e1 = -1; e2 = -1; o1 = '0; o2 = '0;
    in_1 = '0; in_2 = '0; in_3 = '0; mute = '0; in_0 = 16'sd111;
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        nv++;
        if (nv == 1) begin e1 = c; o1 = out; end else begin e2 = c; o2 = out; end
      end
      if (c == 1) in_0 = 16'sd222;
      audio_clk_en = (c == 0 || c == k);
      @(posedge clk); #1;
    end
    audio_clk_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    int nv, e1, e2; logic signed [15:0] o1, o2;
    run_sched(6, nv, e1, e2, o1, o2);
    checks++; if (nv !== 2 || e1 !== 6 || e2 !== 12) begin
      errors++; $display("FAIL b2b_accept: valids %0d at %0d,%0d want 2 at 6,12", nv, e1, e2);
    end
    checks++; if (o1 !== 16'sd111 || o2 !== 16'sd222) begin
      errors++; $display("FAIL b2b_values: got %0d,%0d want 111,222", o1, o2);
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_overrun;
    int nv, e1, e2; logic signed [15:0] o1, o2;
    run_sched(3, nv, e1, e2, o1, o2);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
    checks++; if (nv !== 1 || e1 !== 6 || o1 !== 16'sd111) begin
      errors++; $display("FAIL overrun_single_valid: valids %0d at %0d out %0d want 1 at 6 out 111", nv, e1, o1);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid;
    int nvalid; int lat; logic signed [15:0] o, og; logic c, cg;
    in_0 = 16'sd1000; in_1 = '0; in_2 = '0; in_3 = '0; mute = '0;
    @(posedge clk); #1 audio_clk_en = 1'b1;
    @(posedge clk); #1 audio_clk_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #3 reset = 1'b0;
    checks++; if (out !== 16'sd0 || overrun !== 1'b0) begin
      errors++; $display("FAIL midreset_state: out %0d overrun %b want 0/0", out, overrun);
    end
    nvalid = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (out_valid) nvalid++;
    end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL midreset_no_valid: got %0d pulses want 0", nvalid); end
    run_sample(lat, o, og, c, cg);
    checks++; if (lat !== c_LAT || o !== 16'sd1000) begin
      errors++; $display("FAIL midreset_recover: lat %0d out %0d want %0d/1000", lat, o, c_LAT);
    end
  endtask

`ifdef DK_MIXER_DC_BLOCK_EN
  task automatic test_dc_block;
    int lat; logic signed [15:0] o, og; logic c, cg;
    in_0 = 16'sd8000; in_1 = '0; in_2 = '0; in_3 = '0; mute = '0;
    run_sample(lat, o, og, c, cg);
    checks++; if (lat !== c_LAT) begin errors++; $display("FAIL dcb_latency: got %0d want %0d", lat, c_LAT); end
    checks++; if (o !== 16'sd8000) begin errors++; $display("FAIL dcb_first: got %0d want 8000", o); end
    for (int s = 1; s < 6000; s++) run_sample(lat, o, og, c, cg);
    checks++; if (!(o < 16'sd64 && o > -16'sd64)) begin errors++; $display("FAIL dcb_settle: got %0d want |out|<64", o); end
    checks++; if (lat !== c_LAT) begin errors++; $display("FAIL dcb_latency_late: got %0d want %0d", lat, c_LAT); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DK_MIXER_DC_BLOCK_EN
    test_dc_block();
`else
    test_single();
    test_saturation();
    test_gain_mute();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
